// File: rtl/cache_with_interface_if.sv
// Request/response bundle between the wrapper and its cache-set stage.
// The wrapper drives the request; the set stage drives the response.
interface cache_with_interface_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] w_request;
    logic [WIDTH-1:0] w_response;

    modport wrapper (output w_request, input  w_response);
    modport set     (input  w_request, output w_response);
endinterface

// File: rtl/cache_with_interface.sv
// Cache-set stage registering the inverted request, and the top wrapper
// that connects it to dataIn/dataOut through the request/response bundle.
module cache_with_interface_set #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 clear,
    cache_with_interface_if.set  bus
);
    logic [WIDTH-1:0] r_response;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_response <= '0;
        end else begin
            r_response <= ~bus.w_request;
        end
    end

    assign bus.w_response = r_response;
endmodule

module cache_with_interface #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut
);
    cache_with_interface_if #(.WIDTH(WIDTH)) u_bus ();

    assign u_bus.w_request = dataIn;
    assign dataOut         = u_bus.w_response;

    cache_with_interface_set #(.WIDTH(WIDTH)) u_set (
        .clock (clock),
        .clear (clear),
        .bus   (u_bus.set)
    );
endmodule

// File: tb/tb_cache_with_interface.sv
// Directed bench for cache_with_interface: reset hold, clear release,
// full 256-value sweep, mid-run clear and alternating patterns.
module tb_cache_with_interface;
    logic       clock;
    logic       clear;
    logic [7:0] dataIn;
    logic [7:0] dataOut;

    int unsigned total = 0;
    int unsigned bad   = 0;

    cache_with_interface #(.WIDTH(8)) dut (
        .clock   (clock),
        .clear   (clear),
        .dataIn  (dataIn),
        .dataOut (dataOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle just past it before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] cnt;
        logic [7:0] pat;

        clear  = 1'b1;
        dataIn = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            check("reset_hold", dataOut, 8'h00);
        end

        dataIn = 8'hA5;
        step();
        check("reset_ignores_data", dataOut, 8'h00);
        step();
        check("reset_ignores_data2", dataOut, 8'h00);

        dataIn = 8'h00;
        clear  = 1'b0;
        step();
        check("clear_release", dataOut, 8'hFF);

        cnt    = 8'h00;
        dataIn = 8'h00;
        for (int i = 0; i < 256; i++) begin
            step();
            check("sweep", ~dataOut, cnt);
            cnt    = cnt + 8'h01;
            dataIn = dataIn + 8'h01;
        end
        check("sweep_final", dataOut, 8'h00);

        dataIn = 8'h3C;
        step();
        check("pre_clear", dataOut, 8'hC3);
        clear = 1'b1;
        step();
        check("mid_clear", dataOut, 8'h00);
        clear = 1'b0;
        step();
        check("post_clear", dataOut, 8'hC3);

        pat = 8'h55;
        for (int i = 0; i < 8; i++) begin
            dataIn = pat;
            step();
            check("alternate", dataOut, (i % 2 == 0) ? 8'hAA : 8'h55);
            pat = (pat == 8'h55) ? 8'hAA : 8'h55;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_with_interface.md
Name: cache_with_interface

Overview:
- Small registered data-transform block: a top wrapper feeding an internal cache-set stage over a request/response bundle.
- Each cycle the wrapper forwards dataIn as the request.
- The cache-set stage registers the bitwise complement of the request as its response.
- The wrapper drives the response out on dataOut.
- Used as a structural test of hierarchical bundle (interface) connectivity; the datapath is one register stage.

Parameters:
- WIDTH, 8, data width of dataIn, dataOut, the internal request and the internal response.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- clear  input  1  synchronous, active-high reset.
- dataIn  input  WIDTH  request data, sampled on each rising clock edge.
- dataOut  output  WIDTH  registered response: complement of the previously sampled dataIn.

Behaviour:
- Interface: one clock (clock); reset is clear, synchronous and active-high.
- Structure:
  - Wrapper contains a request/response bundle: request WIDTH bits, wrapper to set; response WIDTH bits, set to wrapper.
  - Wrapper contains one cache-set submodule connected through that bundle.
  - request = dataIn, combinational.
  - dataOut = response, combinational.
- Response register, on each rising edge of clock:
  - If clear = 1: response <= 0.
  - Else: response <= ~request, bitwise inversion of all WIDTH bits.
- Latency:
  - Exactly one cycle: dataIn at edge N appears inverted on dataOut immediately after edge N.
  - It holds until edge N+1.
- Reset:
  - dataOut = 8'h00 from the first edge with clear = 1.
  - dataOut stays 8'h00 for every cycle clear is held, regardless of dataIn.
- Clear release:
  - The first edge with clear = 0 loads ~dataIn.
  - There is no extra bubble cycle.
- Reset mid-operation: clear asserted at any edge forces 0 at that edge, overriding the inversion.
- Before the first clock edge, the dataOut value is undefined; no power-on value is required.
- Widths:
  - No arithmetic, no carry.
  - All WIDTH bits are inverted independently.
  - No truncation or extension inside the block.
- No handshake, no stall, no enable: a new value is accepted every cycle.
- No other state exists; the block is fully deterministic from dataIn and clear.

Test Plan:
- Hold clear = 1 for 4 edges with dataIn = 8'h00 -> dataOut = 8'h00 after each edge.
- Hold clear = 1 with dataIn = 8'hA5 -> dataOut stays 8'h00.
- Release clear with dataIn = 8'h00 -> after the next edge dataOut = 8'hFF.
- Sweep with clear = 0:
  - Drive dataIn 8'h00..8'hFF, incrementing by 1 right after each edge.
  - Sample after each edge once the register has updated.
  - Required: ~dataOut equals a counter starting at 0 and incrementing by 1 per edge, for all 256 values.
  - Final value dataIn = 8'hFF -> dataOut = 8'h00.
- Drive dataIn = 8'h3C, then assert clear for one edge -> dataOut = 8'h00. Deassert clear with dataIn = 8'h3C -> next edge dataOut = 8'hC3.
- Alternate dataIn 8'h55/8'hAA each cycle -> dataOut alternates 8'hAA/8'h55, trailing by one edge.
